// File: rtl/multu_hilo_if.sv
// multu_hilo_if: bundle between the execute stage and the MultU/HI-LO unit.
//   master: drives start, op_a, op_b, mf_req, mf_sel; observes the results
//   slave : the unit; drives mf_data, hi, lo, busy, done, stall
interface multu_hilo_if #(parameter int WIDTH = 32);
   logic             start;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             mf_req;
   logic             mf_sel;
   logic [WIDTH-1:0] mf_data;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;
   logic             stall;
   modport master (output start, op_a, op_b, mf_req, mf_sel,
                   input mf_data, hi, lo, busy, done, stall);
   modport slave (input start, op_a, op_b, mf_req, mf_sel,
                  output mf_data, hi, lo, busy, done, stall);
endinterface

// File: rtl/multu_hilo_unit.sv
// multu_hilo_unit: iterative radix-2 unsigned multiplier owning the HI/LO pair.
//   clk, rst : clock, synchronous active-high reset
//   s        : multu_hilo_if slave (start/op_a/op_b issue, mf_req/mf_sel reads,
//              mf_data/hi/lo results, busy/done status, stall to the pipeline)
//   Define MULTU_EARLY_OUT_EN to commit as soon as the remaining multiplier is zero.
module multu_hilo_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input logic           clk,
   input logic           rst,
   multu_hilo_if.slave   s
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t               state, state_n;
   logic [2*WIDTH-1:0]   mcand, acc, acc_n;
   logic [WIDTH-1:0]     mplier, hi, lo;
   logic [CNT_W-1:0]     cnt;
   logic                 last;
   assign acc_n = mplier[0] ? acc + mcand : acc;
`ifdef MULTU_EARLY_OUT_EN
   // nothing left to add once the shifted multiplier runs out of ones
   assign last = (mplier >> 1) == '0 || cnt == CNT_W'(WIDTH - 1);
`else
   assign last = cnt == CNT_W'(WIDTH - 1);
`endif
   always_ff @(posedge clk)
      state <= rst ? IDLE : state_n;
   // IDLE and DONE behave alike: start launches, otherwise settle in IDLE
   always_comb begin
      state_n = state;
      state_n = state == BUSY ? (last ? DONE : BUSY) : (s.start ? BUSY : IDLE);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
         hi     <= '0;
         lo     <= '0;
      end else if (state != BUSY) begin
         if (s.start) begin
            mcand  <= {{WIDTH{1'b0}}, s.op_a};
            mplier <= s.op_b;
            acc    <= '0;
            cnt    <= '0;
         end
      end else begin
         acc    <= acc_n;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
         if (last) {hi, lo} <= acc_n;
      end
   end
   assign s.hi      = hi;
   assign s.lo      = lo;
   assign s.mf_data = s.mf_sel ? hi : lo;
   assign s.busy    = state == BUSY;
   assign s.done    = state == DONE;
   assign s.stall   = s.busy & (s.mf_req | s.start);
endmodule
